// File: rtl/fp_swap_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_swap_align_stage
// Purpose  : Operand swap, exponent difference and significand alignment
//            (guard/round/sticky) for the shared FP32 / FP16x2 adder.
//            Build option FPU_ALIGN_ONE_STAGE_EN folds swap and align into one
//            combinational path ahead of a single register stage.
// Revision : 1.0 - initial release
// ============================================================================

package fp_swap_align_pkg;
    typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } fp_lanes_t;
    typedef union packed {
        logic [31:0] w;
        fp_lanes_t   lanes;
    } fp_vec_u;
endpackage

module fp_swap_align_stage
    import fp_swap_align_pkg::*;
#(
    parameter int GRS_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  fp_fmt_e             i_fmt,
    input  logic                i_sub,
    input  fp_vec_u             i_x,
    input  fp_vec_u             i_y,
    input  logic                i_swap_h,
    input  logic                i_swap_l,
    output logic                o_valid,
    input  logic                i_ready,
    output fp_fmt_e             o_fmt,
    output logic                o_sign_h,
    output logic                o_sign_l,
    output logic                o_effsub_h,
    output logic                o_effsub_l,
    output logic [7:0]          o_exp_h,
    output logic [4:0]          o_exp_l,
    output logic [24+GRS_W-1:0] o_mbig_h,
    output logic [24+GRS_W-1:0] o_msml_h,
    output logic [11+GRS_W-1:0] o_mbig_l,
    output logic [11+GRS_W-1:0] o_msml_l
);

    localparam int         c_WH     = 24 + GRS_W;
    localparam int         c_WL     = 11 + GRS_W;
    localparam logic [7:0] c_SAT32  = 8'(c_WH);
    localparam logic [7:0] c_SAT16  = 8'(c_WL);
    localparam logic [4:0] c_SATL   = 5'(c_WL);

    typedef struct packed {
        fp_fmt_e         fmt;
        logic            sign_h;
        logic            sign_l;
        logic            effsub_h;
        logic            effsub_l;
        logic [7:0]      exp_h;
        logic [4:0]      exp_l;
        logic [c_WH-1:0] mbig_h;
        logic [c_WH-1:0] msml_h;
        logic [c_WL-1:0] mbig_l;
        logic [c_WL-1:0] msml_l;
        logic [7:0]      d_h;
        logic [4:0]      d_l;
    } s1_t;

    typedef struct packed {
        fp_fmt_e         fmt;
        logic            sign_h;
        logic            sign_l;
        logic            effsub_h;
        logic            effsub_l;
        logic [7:0]      exp_h;
        logic [4:0]      exp_l;
        logic [c_WH-1:0] mbig_h;
        logic [c_WH-1:0] msml_h;
        logic [c_WL-1:0] mbig_l;
        logic [c_WL-1:0] msml_l;
    } s2_t;

    // Subnormals (exponent field 0) share the scale of exponent 1.
    function automatic logic [7:0] eff_exp8(input logic [7:0] e);
        return (e == 8'd0) ? 8'd1 : e;
    endfunction

    function automatic logic [4:0] eff_exp5(input logic [4:0] e);
        return (e == 5'd0) ? 5'd1 : e;
    endfunction

    function automatic logic [c_WH-1:0] sig32(input logic [31:0] v);
        return {|v[30:23], v[22:0], {GRS_W{1'b0}}};
    endfunction

    function automatic logic [c_WL-1:0] sig16(input logic [15:0] v);
        return {|v[14:10], v[9:0], {GRS_W{1'b0}}};
    endfunction

    function automatic logic [c_WH-1:0] align_h(input logic [c_WH-1:0] m,
                                                input logic [7:0]      d,
                                                input logic            fp16);
        logic [c_WH-1:0] lost;
        logic [c_WH-1:0] res;
        logic            sat;
        sat    = fp16 ? (d >= c_SAT16) : (d >= c_SAT32);
        lost   = m & ~({c_WH{1'b1}} << d);
        res    = m >> d;
        res[0] = res[0] | (|lost);
        if (sat) begin
            res = {{(c_WH-1){1'b0}}, |m};
        end
        return res;
    endfunction

    function automatic logic [c_WL-1:0] align_l(input logic [c_WL-1:0] m,
                                                input logic [4:0]      d);
        logic [c_WL-1:0] lost;
        logic [c_WL-1:0] res;
        lost   = m & ~({c_WL{1'b1}} << d);
        res    = m >> d;
        res[0] = res[0] | (|lost);
        if (d >= c_SATL) begin
            res = {{(c_WL-1){1'b0}}, |m};
        end
        return res;
    endfunction

    s1_t         w_s1;
    s1_t         w_a;
    logic        w_a_valid;
    s2_t         w_s2;
    s2_t         r_s2;
    logic        r_s2_valid;
    logic        w_s2_load;
    logic [31:0] w_y32;
    logic [31:0] w_big32;
    logic [31:0] w_sml32;
    logic [15:0] w_yh;
    logic [15:0] w_bh;
    logic [15:0] w_sh;
    logic [15:0] w_yl;
    logic [15:0] w_bl;
    logic [15:0] w_sl;

    // Swap: order each lane so the comparator's larger magnitude is "big".
    always_comb begin
        w_s1    = '0;
        w_y32   = i_y.w ^ {i_sub, 31'b0};
        w_big32 = i_swap_h ? w_y32 : i_x.w;
        w_sml32 = i_swap_h ? i_x.w : w_y32;
        w_yh    = i_y.lanes.hi ^ {i_sub, 15'b0};
        w_bh    = i_swap_h ? w_yh : i_x.lanes.hi;
        w_sh    = i_swap_h ? i_x.lanes.hi : w_yh;
        w_yl    = i_y.lanes.lo ^ {i_sub, 15'b0};
        w_bl    = i_swap_l ? w_yl : i_x.lanes.lo;
        w_sl    = i_swap_l ? i_x.lanes.lo : w_yl;
        w_s1.fmt = i_fmt;
        if (i_fmt == FP32) begin
            w_s1.sign_h   = w_big32[31];
            w_s1.effsub_h = w_big32[31] ^ w_sml32[31];
            w_s1.exp_h    = w_big32[30:23];
            w_s1.d_h      = eff_exp8(w_big32[30:23]) - eff_exp8(w_sml32[30:23]);
            w_s1.mbig_h   = sig32(w_big32);
            w_s1.msml_h   = sig32(w_sml32);
        end else begin
            w_s1.sign_h   = w_bh[15];
            w_s1.effsub_h = w_bh[15] ^ w_sh[15];
            w_s1.exp_h    = {3'b000, w_bh[14:10]};
            w_s1.d_h      = {3'b000, eff_exp5(w_bh[14:10]) - eff_exp5(w_sh[14:10])};
            w_s1.mbig_h   = {{(c_WH-c_WL){1'b0}}, sig16(w_bh)};
            w_s1.msml_h   = {{(c_WH-c_WL){1'b0}}, sig16(w_sh)};
            w_s1.sign_l   = w_bl[15];
            w_s1.effsub_l = w_bl[15] ^ w_sl[15];
            w_s1.exp_l    = w_bl[14:10];
            w_s1.d_l      = eff_exp5(w_bl[14:10]) - eff_exp5(w_sl[14:10]);
            w_s1.mbig_l   = sig16(w_bl);
            w_s1.msml_l   = sig16(w_sl);
        end
    end

    assign w_s2_load = ~r_s2_valid | i_ready;

`ifdef FPU_ALIGN_ONE_STAGE_EN
    assign w_a       = w_s1;
    assign w_a_valid = i_valid;
    assign o_ready   = w_s2_load;
`else
    s1_t  r_s1;
    logic r_s1_valid;

    assign w_a       = r_s1;
    assign w_a_valid = r_s1_valid;
    assign o_ready   = ~r_s1_valid | w_s2_load;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (o_ready) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1 <= w_s1;
            end
        end
    end
`endif

    always_comb begin
        w_s2          = '0;
        w_s2.fmt      = w_a.fmt;
        w_s2.sign_h   = w_a.sign_h;
        w_s2.sign_l   = w_a.sign_l;
        w_s2.effsub_h = w_a.effsub_h;
        w_s2.effsub_l = w_a.effsub_l;
        w_s2.exp_h    = w_a.exp_h;
        w_s2.exp_l    = w_a.exp_l;
        w_s2.mbig_h   = w_a.mbig_h;
        w_s2.mbig_l   = w_a.mbig_l;
        w_s2.msml_h   = align_h(w_a.msml_h, w_a.d_h, w_a.fmt == FP16);
        w_s2.msml_l   = align_l(w_a.msml_l, w_a.d_l);
    end

    // Output register only loads on a real beat, so held data never changes.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= w_a_valid;
            if (w_a_valid) begin
                r_s2 <= w_s2;
            end
        end
    end

    assign o_valid    = r_s2_valid;
    assign o_fmt      = r_s2.fmt;
    assign o_sign_h   = r_s2.sign_h;
    assign o_sign_l   = r_s2.sign_l;
    assign o_effsub_h = r_s2.effsub_h;
    assign o_effsub_l = r_s2.effsub_l;
    assign o_exp_h    = r_s2.exp_h;
    assign o_exp_l    = r_s2.exp_l;
    assign o_mbig_h   = r_s2.mbig_h;
    assign o_msml_h   = r_s2.msml_h;
    assign o_mbig_l   = r_s2.mbig_l;
    assign o_msml_l   = r_s2.msml_l;

endmodule

`default_nettype wire

// File: tb/tb_fp_swap_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_swap_align_stage
// Purpose  : Directed vectors with a queued scoreboard for fp_swap_align_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_swap_align_stage;
    import fp_swap_align_pkg::*;

    localparam int GRS_W = 3;
`ifdef FPU_ALIGN_ONE_STAGE_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    fp_fmt_e     i_fmt = FP32;
    logic        i_sub = 1'b0;
    fp_vec_u     i_x = '0;
    fp_vec_u     i_y = '0;
    logic        i_swap_h = 1'b0;
    logic        i_swap_l = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    fp_fmt_e     o_fmt;
    logic        o_sign_h, o_sign_l, o_effsub_h, o_effsub_l;
    logic [7:0]  o_exp_h;
    logic [4:0]  o_exp_l;
    logic [26:0] o_mbig_h, o_msml_h;
    logic [13:0] o_mbig_l, o_msml_l;

    typedef struct packed {
        logic        fmt;
        logic        sign_h;
        logic        sign_l;
        logic        effsub_h;
        logic        effsub_l;
        logic [7:0]  exp_h;
        logic [4:0]  exp_l;
        logic [26:0] mbig_h;
        logic [26:0] msml_h;
        logic [13:0] mbig_l;
        logic [13:0] msml_l;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
        bit    lat_chk;
    } sb_t;

    sb_t   q[$];
    beat_t act;
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    saw_stall = 1'b0;

    fp_swap_align_stage #(.GRS_W(GRS_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_fmt(i_fmt), .i_sub(i_sub), .i_x(i_x), .i_y(i_y),
        .i_swap_h(i_swap_h), .i_swap_l(i_swap_l), .o_valid(o_valid),
        .i_ready(i_ready), .o_fmt(o_fmt), .o_sign_h(o_sign_h),
        .o_sign_l(o_sign_l), .o_effsub_h(o_effsub_h), .o_effsub_l(o_effsub_l),
        .o_exp_h(o_exp_h), .o_exp_l(o_exp_l), .o_mbig_h(o_mbig_h),
        .o_msml_h(o_msml_h), .o_mbig_l(o_mbig_l), .o_msml_l(o_msml_l)
    );

    assign act = {o_fmt, o_sign_h, o_sign_l, o_effsub_h, o_effsub_l, o_exp_h,
                  o_exp_l, o_mbig_h, o_msml_h, o_mbig_l, o_msml_l};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk32(input logic s, input logic es,
                                   input logic [7:0] e, input logic [26:0] mb,
                                   input logic [26:0] ms);
        beat_t b;
        b          = '0;
        b.sign_h   = s;
        b.effsub_h = es;
        b.exp_h    = e;
        b.mbig_h   = mb;
        b.msml_h   = ms;
        return b;
    endfunction

    function automatic beat_t mk16(input logic sh, input logic esh,
                                   input logic [4:0] eh, input logic [13:0] mbh,
                                   input logic [13:0] msh, input logic sl,
                                   input logic esl, input logic [4:0] el,
                                   input logic [13:0] mbl, input logic [13:0] msl);
        beat_t b;
        b          = '0;
        b.fmt      = 1'b1;
        b.sign_h   = sh;
        b.effsub_h = esh;
        b.exp_h    = {3'b000, eh};
        b.mbig_h   = {13'b0, mbh};
        b.msml_h   = {13'b0, msh};
        b.sign_l   = sl;
        b.effsub_l = esl;
        b.exp_l    = el;
        b.mbig_l   = mbl;
        b.msml_l   = msl;
        return b;
    endfunction

    task automatic send(input fp_fmt_e fmt, input logic sub, input logic [31:0] x,
                        input logic [31:0] y, input logic sh, input logic sl,
                        input beat_t e, input bit lat);
        int tries;
        tries = 0;
        @(negedge clk);
        i_valid  = 1'b1;
        i_fmt    = fmt;
        i_sub    = sub;
        i_x      = x;
        i_y      = y;
        i_swap_h = sh;
        i_swap_l = sl;
        #1;
        while (!o_ready) begin
            saw_stall = 1'b1;
            tries++;
            if (tries > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, tries);
                i_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        q.push_back('{b: e, cyc: cyc, lat_chk: lat});
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (o_valid || act != '0 || !o_ready) begin
            n_err++;
            $display("FAIL %s: o_valid=%0b o_ready=%0b data=%h, required 0/1/0",
                     name, o_valid, o_ready, act);
        end
    endtask

    // Fill every stage while stalled, then clear via reset or flush.
    task automatic fill_and_clear(input bit use_rst);
        @(negedge clk);
        i_ready = 1'b0;
        for (int k = 0; k < c_LAT; k++) begin
            send(FP32, 1'b0, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0,
                 mk32(1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000), 1'b0);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (o_ready || !o_valid) begin
            n_err++;
            $display("FAIL full: o_ready=%0b o_valid=%0b, required 0/1", o_ready, o_valid);
        end
        @(negedge clk);
        if (use_rst) rst_n = 1'b0;
        else         i_flush = 1'b1;
        i_valid = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        check_idle(use_rst ? "after_reset" : "after_flush");
        @(negedge clk);
        i_ready = 1'b1;
        send(FP32, 1'b0, 32'h3F000000, 32'h40000000, 1'b1, 1'b0,
             mk32(1'b0, 1'b0, 8'h80, 27'h4000000, 27'h1000000), 1'b1);
        drain();
    endtask

    // Scoreboard monitor
    initial begin
        sb_t   e;
        beat_t held_b;
        bit    held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || i_flush) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    n_cmp++;
                    if (!o_valid || act != held_b) begin
                        n_err++;
                        $display("FAIL hold: o_valid=%0b data=%h, required 1 %h", o_valid, act, held_b);
                    end
                    held = 1'b0;
                end
                if (o_valid && i_ready) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL spurious: unexpected beat %h, required none", act);
                    end else begin
                        e = q.pop_front();
                        if (act != e.b) begin
                            n_err++;
                            $display("FAIL data: got %h, required %h", act, e.b);
                        end
                        if (e.lat_chk) begin
                            n_cmp++;
                            if (cyc - e.cyc != c_LAT) begin
                                n_err++;
                                $display("FAIL latency: got %0d, required %0d", cyc - e.cyc, c_LAT);
                            end
                        end
                    end
                end else if (o_valid) begin
                    held   = 1'b1;
                    held_b = act;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_state");

        send(FP32, 1'b0, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0,
             mk32(1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000), 1'b1);
        drain();
        send(FP32, 1'b0, 32'h3F000000, 32'h40000000, 1'b1, 1'b1,
             mk32(1'b0, 1'b0, 8'h80, 27'h4000000, 27'h1000000), 1'b1);
        send(FP32, 1'b0, 32'h4B800000, 32'h3F800000, 1'b0, 1'b0,
             mk32(1'b0, 1'b0, 8'h97, 27'h4000000, 27'h0000004), 1'b0);
        send(FP32, 1'b0, 32'h4F000000, 32'h3F800000, 1'b0, 1'b0,
             mk32(1'b0, 1'b0, 8'h9E, 27'h4000000, 27'h0000001), 1'b0);
        send(FP16, 1'b1, 32'h3C003800, 32'h38003C00, 1'b0, 1'b1,
             mk16(1'b0, 1'b1, 5'h0F, 14'h2000, 14'h1000,
                  1'b1, 1'b1, 5'h0F, 14'h2000, 14'h1000), 1'b0);
        send(FP32, 1'b0, 32'h41800000, 32'h3F800001, 1'b0, 1'b0,
             mk32(1'b0, 1'b0, 8'h83, 27'h4000000, 27'h0400001), 1'b0);
        send(FP32, 1'b1, 32'h40400000, 32'h40000000, 1'b0, 1'b0,
             mk32(1'b0, 1'b1, 8'h80, 27'h6000000, 27'h4000000), 1'b0);
        send(FP16, 1'b0, 32'h04003C00, 32'h00013C00, 1'b0, 1'b0,
             mk16(1'b0, 1'b0, 5'h01, 14'h2000, 14'h0008,
                  1'b0, 1'b0, 5'h0F, 14'h2000, 14'h2000), 1'b0);
        send(FP16, 1'b0, 32'h74007800, 32'h3C00BC00, 1'b0, 1'b0,
             mk16(1'b0, 1'b0, 5'h1D, 14'h2000, 14'h0001,
                  1'b0, 1'b1, 5'h1E, 14'h2000, 14'h0001), 1'b0);
        send(FP32, 1'b0, 32'h7F800000, 32'h3F800000, 1'b0, 1'b0,
             mk32(1'b0, 1'b0, 8'hFF, 27'h4000000, 27'h0000001), 1'b0);
        drain();

        saw_stall = 1'b0;
        fork
            begin
                send(FP32, 1'b0, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0,
                     mk32(1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000), 1'b0);
                send(FP32, 1'b0, 32'h3F800000, 32'h3E800000, 1'b0, 1'b0,
                     mk32(1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h1000000), 1'b0);
                send(FP32, 1'b0, 32'h3F800000, 32'h3E000000, 1'b0, 1'b0,
                     mk32(1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0800000), 1'b0);
                send(FP32, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0,
                     mk32(1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h4000000), 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                i_ready = 1'b0;
                repeat (3) @(negedge clk);
                i_ready = 1'b1;
            end
        join
        drain();
        n_cmp++;
        if (!saw_stall) begin
            n_err++;
            $display("FAIL backpressure: o_ready stayed 1 with output stalled, required a drop");
        end

        fill_and_clear(1'b0);
        fill_and_clear(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
